// File: rtl/mem_write_hls_deadlock_reporter.sv
// Qualifies HLS deadlock-monitor block flags by persistence and latches one sticky deadlock
// report (first tripped index, trip timestamp, flag snapshot) behind a valid/ready handshake.
module mem_write_hls_deadlock_reporter #(
    parameter int unsigned NUM_MONITORS = 4,
    parameter int unsigned THRESHOLD    = 1024,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TS_W         = 32,
    parameter int unsigned IDX_W        = ($clog2(NUM_MONITORS) > 0) ? $clog2(NUM_MONITORS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_MONITORS-1:0] block_sigs,
    input  logic                    enable,
    input  logic                    clear,
    output logic                    deadlock,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [IDX_W-1:0]        report_idx,
    output logic [TS_W-1:0]         report_cycle,
    output logic [NUM_MONITORS-1:0] report_mask
);

    localparam logic [CNT_W-1:0] TripCnt = CNT_W'(THRESHOLD - 1);

    typedef enum logic [1:0] {StWatch, StReport, StHalted} state_e;

    state_e                  state_q, state_d;
    logic [TS_W-1:0]         ts_q, ts_d;
    logic [CNT_W-1:0]        cnt_q [NUM_MONITORS];
    logic [CNT_W-1:0]        cnt_d [NUM_MONITORS];
    logic                    deadlock_q, deadlock_d;
    logic                    valid_q, valid_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TS_W-1:0]         cycle_q, cycle_d;
    logic [NUM_MONITORS-1:0] mask_q, mask_d;

    logic [NUM_MONITORS-1:0] trip;
    logic [IDX_W-1:0]        trip_idx;

    // Descending scan so the lowest tripping index wins.
    always_comb begin
        trip     = '0;
        trip_idx = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
            if (enable && block_sigs[i] && (cnt_q[i] == TripCnt)) begin
                trip[i]  = 1'b1;
                trip_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + TS_W'(1);
        cnt_d      = cnt_q;
        deadlock_d = deadlock_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        cycle_d    = cycle_q;
        mask_d     = mask_q;

        if (clear) begin
            state_d    = StWatch;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
            for (int i = 0; i < NUM_MONITORS; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                StWatch: begin
                    for (int i = 0; i < NUM_MONITORS; i++) begin
                        cnt_d[i] = (enable && block_sigs[i]) ? cnt_q[i] + CNT_W'(1) : '0;
                    end
                    if (|trip) begin
                        state_d    = StReport;
                        deadlock_d = 1'b1;
                        valid_d    = 1'b1;
                        idx_d      = trip_idx;
                        cycle_d    = ts_q;
                        mask_d     = block_sigs;
                    end
                end
                StReport: begin
                    if (report_ready) begin
                        valid_d = 1'b0;
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                end
                default: state_d = StWatch;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StWatch;
            ts_q       <= '0;
            deadlock_q <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            cycle_q    <= '0;
            mask_q     <= '0;
            for (int i = 0; i < NUM_MONITORS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            deadlock_q <= deadlock_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            cycle_q    <= cycle_d;
            mask_q     <= mask_d;
            for (int i = 0; i < NUM_MONITORS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign deadlock     = deadlock_q;
    assign report_valid = valid_q;
    assign report_idx   = idx_q;
    assign report_cycle = cycle_q;
    assign report_mask  = mask_q;

endmodule

// File: tb/tb_mem_write_hls_deadlock_reporter.sv
// Scoreboard bench: a run-length reference model queues expected reports; a negedge monitor
// pops and compares whenever the DUT presents a new report.
module tb_mem_write_hls_deadlock_reporter;

    localparam int NM  = 4;
    localparam int THR = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NM-1:0] block_sigs = '0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          report_ready = 1'b1;
    logic          deadlock;
    logic          report_valid;
    logic [1:0]    report_idx;
    logic [31:0]   report_cycle;
    logic [NM-1:0] report_mask;

    mem_write_hls_deadlock_reporter #(
        .NUM_MONITORS(NM),
        .THRESHOLD   (THR),
        .CNT_W       (16),
        .TS_W        (32)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .block_sigs  (block_sigs),
        .enable      (enable),
        .clear       (clear),
        .deadlock    (deadlock),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_idx  (report_idx),
        .report_cycle(report_cycle),
        .report_mask (report_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic [31:0] cyc;
        logic [3:0]  mask;
    } rep_t;

    rep_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count each monitor's current run of blocked cycles; a run reaching
    // THR while watching raises a report.
    int          run [NM];
    int          mode = 0;  // 0 watching, 1 reporting, 2 halted
    bit          m_dead = 0;
    bit          m_valid = 0;
    logic [31:0] m_ts = '0;

    always @(posedge clock) begin
        if (!reset_n) begin
            mode = 0; m_dead = 0; m_valid = 0; m_ts = '0;
            foreach (run[i]) run[i] = 0;
        end else begin
            if (clear) begin
                mode = 0; m_dead = 0; m_valid = 0;
                foreach (run[i]) run[i] = 0;
            end else if (mode == 0) begin
                int first;
                first = -1;
                for (int i = 0; i < NM; i++) begin
                    if (enable && block_sigs[i]) begin
                        run[i]++;
                        if (run[i] == THR && first < 0) first = i;
                    end else begin
                        run[i] = 0;
                    end
                end
                if (first >= 0) begin
                    rep_t r;
                    r.idx = first; r.cyc = m_ts; r.mask = block_sigs;
                    exp_q.push_back(r);
                    mode = 1; m_dead = 1; m_valid = 1;
                end
            end else if (mode == 1 && report_ready) begin
                m_valid = 0; mode = 2;
            end
            m_ts = m_ts + 32'd1;
        end
    end

    // Monitor
    bit   prev_valid = 0;
    rep_t cur;
    always @(negedge clock) begin
        chk("deadlock", 64'(deadlock), 64'(m_dead));
        chk("report_valid", 64'(report_valid), 64'(m_valid));
        if (report_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", 64'(1), 64'(0));
            end else begin
                cur = exp_q.pop_front();
                chk("report_idx", 64'(report_idx), 64'(cur.idx));
                chk("report_cycle", 64'(report_cycle), 64'(cur.cyc));
                chk("report_mask", 64'(report_mask), 64'(cur.mask));
            end
        end else if (report_valid && prev_valid) begin
            chk("hold_idx", 64'(report_idx), 64'(cur.idx));
            chk("hold_cycle", 64'(report_cycle), 64'(cur.cyc));
            chk("hold_mask", 64'(report_mask), 64'(cur.mask));
        end
        prev_valid = report_valid;
    end

    task automatic step(input logic [NM-1:0] b, input logic e, input logic c, input logic r);
        block_sigs   = b;
        enable       = e;
        clear        = c;
        report_ready = r;
        @(negedge clock);
    endtask

    task automatic blocked(input int n, input logic [NM-1:0] b, input logic r);
        for (int k = 0; k < n; k++) step(b, 1'b1, 1'b0, r);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_deadlock"}, 64'(deadlock), 64'(0));
        chk({tag, "_valid"}, 64'(report_valid), 64'(0));
        chk({tag, "_idx"}, 64'(report_idx), 64'(0));
        chk({tag, "_cycle"}, 64'(report_cycle), 64'(0));
        chk({tag, "_mask"}, 64'(report_mask), 64'(0));
    endtask

    initial begin
        @(negedge clock);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        // Single monitor trip
        step('0, 1'b1, 1'b0, 1'b1);
        blocked(THR, 4'b0100, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);

        // Interrupted run never trips
        blocked(THR - 1, 4'b0010, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        blocked(THR - 1, 4'b0010, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        chk("no_trip_interrupted", 64'(deadlock), 64'(0));

        // Simultaneous trip, lowest index wins
        blocked(THR, 4'b1010, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);

        // Backpressure, then halted
        blocked(THR, 4'b0001, 1'b0);
        blocked(5, 4'b0001, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        chk("halted_deadlock", 64'(deadlock), 64'(1));
        blocked(20, 4'b1111, 1'b1);
        chk("halted_no_valid", 64'(report_valid), 64'(0));
        step('0, 1'b1, 1'b1, 1'b1);

        // Clear with ready in REPORT drops the report, then re-arm
        blocked(THR, 4'b0100, 1'b0);
        step('0, 1'b1, 1'b1, 1'b1);
        chk("clear_deadlock", 64'(deadlock), 64'(0));
        blocked(THR, 4'b0100, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);

        // Mid-run reset discards partial counts
        blocked(5, 4'b0001, 1'b1);
        reset_n = 1'b0;
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        chk_zero_outputs("midreset");
        reset_n = 1'b1;
        blocked(THR - 1, 4'b0001, 1'b1);
        chk("fresh_run_needed", 64'(deadlock), 64'(0));
        blocked(1, 4'b0001, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) step(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("enable_off", 64'(deadlock), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [NM-1:0] b;
            for (int i = 0; i < NM; i++) b[i] = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            step(b, ($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)));
        end
        reset_n = 1'b1;
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
